// File: rtl/hall_call_panel_pkg.sv
// elevator_pkg: constants and floor-FSM encoding shared by the hall call panel and its controller
package elevator_pkg;
    localparam int N_FLOORS = 4;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    typedef enum logic [1:0] {F_IDLE, F_PENDING, F_OPEN, F_GAP} floor_state_e;
endpackage

// File: rtl/hall_call_panel_if.sv
// hall_call_panel_if: hall buttons and controller status in, f_req pulses and lamps out
interface hall_call_panel_if;
    logic [elevator_pkg::N_FLOORS-1:0] up_btn;
    logic [elevator_pkg::N_FLOORS-1:0] down_btn;
    logic [1:0] current_floor;
    logic direction;
    logic door_open;
    logic [elevator_pkg::N_FLOORS-1:0] f_req;
    logic [elevator_pkg::N_FLOORS-1:0] up_lamp;
    logic [elevator_pkg::N_FLOORS-1:0] down_lamp;
    logic pending;
    modport master (
        input  up_btn, down_btn, current_floor, direction, door_open,
        output f_req, up_lamp, down_lamp, pending
    );
    modport slave (
        output up_btn, down_btn, current_floor, direction, door_open,
        input  f_req, up_lamp, down_lamp, pending
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus debounce counter, emits a one-cycle press on a stable rise
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0] sync_q;
    logic [CW-1:0] cnt_q;
    logic stable_q;
    logic press_q;
    logic flip;
    assign flip = (sync_q[1] != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q <= '0;
            stable_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            cnt_q <= (sync_q[1] == stable_q || flip) ? '0 : cnt_q + CW'(1);
            stable_q <= stable_q ^ flip;
            press_q <= flip & sync_q[1];
        end
    end
    assign press_o = press_q;
endmodule

// File: rtl/hall_floor_ctrl.sv
// hall_floor_ctrl: per-floor call FSM latching lamps, retiring served calls and re-issuing leftovers
module hall_floor_ctrl
    import elevator_pkg::*;
#(
    parameter int REISSUE_GAP = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic press_up_i,
    input  logic press_dn_i,
    input  logic serve_i,
    input  logic direction_i,
    output logic up_lamp_o,
    output logic dn_lamp_o,
    output logic f_req_o
);
    localparam int GW = $clog2(REISSUE_GAP + 1);
    floor_state_e state_q;
    logic [GW-1:0] gap_q;
    logic up_q, dn_q, f_req_q, up_d, dn_d, set_up, set_dn, retire;
    assign set_up = press_up_i & ~(serve_i & (direction_i == DIR_UP));
    assign set_dn = press_dn_i & ~(serve_i & (direction_i == DIR_DOWN));
    assign retire = serve_i & (state_q == F_PENDING || state_q == F_GAP);
    // Clear the lamp for travel direction if lit, else the opposite one, so one stop retires one call
    assign up_d = set_up | (up_q & ~(retire & (direction_i == DIR_UP ? up_q : ~dn_q)));
    assign dn_d = set_dn | (dn_q & ~(retire & (direction_i == DIR_UP ? ~up_q : dn_q)));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= F_IDLE;
            gap_q <= '0;
            up_q <= 1'b0;
            dn_q <= 1'b0;
            f_req_q <= 1'b0;
        end else begin
            f_req_q <= 1'b0;
            up_q <= up_d;
            dn_q <= dn_d;
            case (state_q)
                F_IDLE: if (set_up | set_dn) begin
                    state_q <= serve_i ? F_OPEN : F_PENDING;
                    f_req_q <= ~serve_i;
                end
                F_PENDING: if (serve_i) state_q <= F_OPEN;
                F_OPEN: if (!serve_i) begin
                    state_q <= (up_d | dn_d) ? F_GAP : F_IDLE;
                    gap_q <= GW'(REISSUE_GAP);
                end
                F_GAP: if (serve_i) begin
                    state_q <= F_OPEN;
                end else if (gap_q == GW'(1)) begin
                    gap_q <= '0;
                    f_req_q <= 1'b1;
                    state_q <= F_PENDING;
                end else begin
                    gap_q <= gap_q - GW'(1);
                end
                default: state_q <= F_IDLE;
            endcase
        end
    end
    assign up_lamp_o = up_q;
    assign dn_lamp_o = dn_q;
    assign f_req_o = f_req_q;
endmodule

// File: rtl/hall_call_panel.sv
// hall_call_panel: debounces hall buttons and runs one call FSM per floor toward the controller's f_req
module hall_call_panel
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REISSUE_GAP = 2
) (
    input  logic clk,
    input  logic rst_n,
    hall_call_panel_if.master bus_io
);
    for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
        logic up_raw, dn_raw;
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
            .clk(clk), .rst_n(rst_n), .btn_i(bus_io.up_btn[f]), .press_o(up_raw)
        );
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
            .clk(clk), .rst_n(rst_n), .btn_i(bus_io.down_btn[f]), .press_o(dn_raw)
        );
        // Top floor has no up call and ground floor no down call
        hall_floor_ctrl #(.REISSUE_GAP(REISSUE_GAP)) u_ctrl (
            .clk(clk),
            .rst_n(rst_n),
            .press_up_i((f != N_FLOORS - 1) && up_raw),
            .press_dn_i((f != 0) && dn_raw),
            .serve_i(bus_io.door_open && (bus_io.current_floor == 2'(f))),
            .direction_i(bus_io.direction),
            .up_lamp_o(bus_io.up_lamp[f]),
            .dn_lamp_o(bus_io.down_lamp[f]),
            .f_req_o(bus_io.f_req[f])
        );
    end
    assign bus_io.pending = |{bus_io.up_lamp, bus_io.down_lamp};
endmodule

// File: tb/tb_hall_call_panel.sv
// tb_hall_call_panel: directed scenarios for the hall call panel with hand-computed expectations
module tb_hall_call_panel;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    hall_call_panel_if bus();
    hall_call_panel #(.DEBOUNCE_CYCLES(4), .REISSUE_GAP(2)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));
    always #5 clk = ~clk;
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic test_reset();
        logic [3:0] seen;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.up_btn = 4'(i * 5);
            bus.down_btn = ~4'(i * 3);
            @(negedge clk);
        end
        checks++; if (bus.f_req !== 4'b0000) begin errors++; $display("FAIL reset_f_req: got %b expected 0000", bus.f_req); end
        checks++; if (bus.up_lamp !== 4'b0000) begin errors++; $display("FAIL reset_up_lamp: got %b expected 0000", bus.up_lamp); end
        checks++; if (bus.down_lamp !== 4'b0000) begin errors++; $display("FAIL reset_down_lamp: got %b expected 0000", bus.down_lamp); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
        bus.up_btn = 4'b0;
        bus.down_btn = 4'b0;
        tick(1);
        rst_n = 1'b1;
        seen = 4'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            seen |= bus.f_req;
        end
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL reset_quiet_f_req: got %b expected 0000", seen); end
    endtask
    task automatic test_single_press();
        logic [3:0] seen;
        bus.up_btn = 4'b0010;
        tick(6);
        checks++; if ({bus.up_lamp, bus.f_req} !== 8'h00) begin errors++; $display("FAIL single_early: lamp/f_req %b expected 00000000", {bus.up_lamp, bus.f_req}); end
        tick(1);
        checks++; if (bus.up_lamp !== 4'b0010) begin errors++; $display("FAIL single_lamp: got %b expected 0010", bus.up_lamp); end
        checks++; if (bus.f_req !== 4'b0010) begin errors++; $display("FAIL single_f_req: got %b expected 0010", bus.f_req); end
        bus.up_btn = 4'b0;
        tick(1);
        checks++; if (bus.f_req !== 4'b0000) begin errors++; $display("FAIL single_pulse_width: got %b expected 0000", bus.f_req); end
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL single_pending: got %b expected 1", bus.pending); end
        tick(8);
        bus.current_floor = 2'd1;
        bus.direction = 1'b1;
        bus.door_open = 1'b1;
        tick(1);
        checks++; if (bus.up_lamp !== 4'b0000) begin errors++; $display("FAIL single_retire: got %b expected 0000", bus.up_lamp); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL single_retire_pending: got %b expected 0", bus.pending); end
        bus.door_open = 1'b0;
        seen = 4'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen |= bus.f_req;
        end
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL single_no_reissue: got %b expected 0000", seen); end
    endtask
    task automatic test_glitch();
        logic [3:0] seen_req, seen_lamp;
        seen_req = 4'b0;
        seen_lamp = 4'b0;
        bus.down_btn = 4'b0100;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (i == 2) bus.down_btn = 4'b0;
            seen_req |= bus.f_req;
            seen_lamp |= bus.down_lamp;
        end
        checks++; if (seen_req !== 4'b0000) begin errors++; $display("FAIL glitch_f_req: got %b expected 0000", seen_req); end
        checks++; if (seen_lamp !== 4'b0000) begin errors++; $display("FAIL glitch_lamp: got %b expected 0000", seen_lamp); end
    endtask
    task automatic test_leftover();
        logic [3:0] seen;
        bus.current_floor = 2'd0;
        bus.up_btn = 4'b0100;
        bus.down_btn = 4'b0100;
        tick(7);
        checks++; if (bus.f_req !== 4'b0100) begin errors++; $display("FAIL leftover_f_req: got %b expected 0100", bus.f_req); end
        checks++; if ({bus.up_lamp, bus.down_lamp} !== 8'b0100_0100) begin errors++; $display("FAIL leftover_lamps: got %b expected 01000100", {bus.up_lamp, bus.down_lamp}); end
        tick(1);
        checks++; if (bus.f_req !== 4'b0000) begin errors++; $display("FAIL leftover_one_pulse: got %b expected 0000", bus.f_req); end
        bus.up_btn = 4'b0;
        bus.down_btn = 4'b0;
        tick(8);
        bus.current_floor = 2'd2;
        bus.direction = 1'b1;
        bus.door_open = 1'b1;
        tick(1);
        checks++; if ({bus.up_lamp, bus.down_lamp, bus.pending} !== 9'b0000_0100_1) begin errors++; $display("FAIL leftover_serve1: got %b expected 000001001", {bus.up_lamp, bus.down_lamp, bus.pending}); end
        seen = 4'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            seen |= bus.f_req;
        end
        bus.door_open = 1'b0;
        tick(2);
        seen |= bus.f_req;
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL leftover_gap_quiet: got %b expected 0000", seen); end
        tick(1);
        checks++; if (bus.f_req !== 4'b0100) begin errors++; $display("FAIL leftover_reissue: got %b expected 0100", bus.f_req); end
        tick(1);
        checks++; if (bus.f_req !== 4'b0000) begin errors++; $display("FAIL leftover_reissue_width: got %b expected 0000", bus.f_req); end
        bus.door_open = 1'b1;
        tick(1);
        checks++; if ({bus.down_lamp, bus.pending} !== 5'b0000_0) begin errors++; $display("FAIL leftover_serve2: got %b expected 00000", {bus.down_lamp, bus.pending}); end
        bus.door_open = 1'b0;
        seen = 4'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen |= bus.f_req;
        end
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL leftover_done_quiet: got %b expected 0000", seen); end
    endtask
    task automatic test_wrong_direction();
        logic [3:0] seen;
        bus.current_floor = 2'd0;
        bus.down_btn = 4'b0010;
        tick(7);
        checks++; if ({bus.down_lamp, bus.f_req} !== 8'b0010_0010) begin errors++; $display("FAIL wrongdir_call: got %b expected 00100010", {bus.down_lamp, bus.f_req}); end
        bus.down_btn = 4'b0;
        tick(8);
        bus.current_floor = 2'd1;
        bus.direction = 1'b1;
        bus.door_open = 1'b1;
        tick(1);
        checks++; if ({bus.down_lamp, bus.pending} !== 5'b0000_0) begin errors++; $display("FAIL wrongdir_retire: got %b expected 00000", {bus.down_lamp, bus.pending}); end
        bus.door_open = 1'b0;
        seen = 4'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen |= bus.f_req | bus.down_lamp;
        end
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL wrongdir_no_reissue: got %b expected 0000", seen); end
    endtask
    task automatic test_simultaneous();
        bus.current_floor = 2'd1;
        bus.up_btn = 4'b0001;
        bus.down_btn = 4'b1000;
        tick(7);
        checks++; if (bus.f_req !== 4'b1001) begin errors++; $display("FAIL simul_f_req: got %b expected 1001", bus.f_req); end
        tick(1);
        checks++; if (bus.f_req !== 4'b0000) begin errors++; $display("FAIL simul_pulse_width: got %b expected 0000", bus.f_req); end
        checks++; if ({bus.up_lamp, bus.down_lamp} !== 8'b0001_1000) begin errors++; $display("FAIL simul_lamps: got %b expected 00011000", {bus.up_lamp, bus.down_lamp}); end
        bus.up_btn = 4'b0;
        bus.down_btn = 4'b0;
        tick(8);
        bus.current_floor = 2'd0;
        bus.direction = 1'b1;
        bus.door_open = 1'b1;
        tick(1);
        checks++; if (bus.up_lamp !== 4'b0000) begin errors++; $display("FAIL simul_floor0_retire: got %b expected 0000", bus.up_lamp); end
        bus.door_open = 1'b0;
        tick(2);
        bus.current_floor = 2'd3;
        bus.door_open = 1'b1;
        tick(1);
        checks++; if ({bus.down_lamp, bus.pending} !== 5'b0000_0) begin errors++; $display("FAIL simul_floor3_retire: got %b expected 00000", {bus.down_lamp, bus.pending}); end
        bus.door_open = 1'b0;
        tick(2);
    endtask
    task automatic test_absorb();
        logic [3:0] seen;
        bus.current_floor = 2'd1;
        bus.direction = 1'b1;
        bus.door_open = 1'b1;
        bus.up_btn = 4'b0010;
        seen = 4'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen |= bus.up_lamp | bus.f_req;
        end
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL absorb_lamp_f_req: got %b expected 0000", seen); end
        bus.up_btn = 4'b0;
        tick(8);
        bus.door_open = 1'b0;
        tick(2);
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL absorb_pending: got %b expected 0", bus.pending); end
    endtask
    task automatic test_reset_in_gap();
        logic [3:0] seen;
        bus.current_floor = 2'd0;
        bus.up_btn = 4'b0100;
        bus.down_btn = 4'b0100;
        tick(7);
        bus.up_btn = 4'b0;
        bus.down_btn = 4'b0;
        tick(8);
        bus.current_floor = 2'd2;
        bus.direction = 1'b1;
        bus.door_open = 1'b1;
        tick(1);
        checks++; if (bus.down_lamp !== 4'b0100) begin errors++; $display("FAIL gapreset_setup: got %b expected 0100", bus.down_lamp); end
        bus.door_open = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.up_lamp, bus.down_lamp, bus.pending} !== 9'b0) begin errors++; $display("FAIL gapreset_clear: got %b expected 000000000", {bus.up_lamp, bus.down_lamp, bus.pending}); end
        tick(1);
        rst_n = 1'b1;
        seen = 4'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen |= bus.f_req | bus.up_lamp | bus.down_lamp;
        end
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL gapreset_quiet: got %b expected 0000", seen); end
    endtask
    initial begin
        bus.up_btn = 4'b0;
        bus.down_btn = 4'b0;
        bus.current_floor = 2'd0;
        bus.direction = 1'b0;
        bus.door_open = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_leftover();
        test_wrong_direction();
        test_simultaneous();
        test_absorb();
        test_reset_in_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
